ac_stream_matcher: RTL and testbench
====================================

Name: ac_stream_matcher

Overview:
- Parametrised, runtime-programmable Aho-Corasick string matcher and successor to the fixed-dictionary TOP engine.
- Consumes one character per handshake and walks goto/fail tables that are loaded through a configuration port.
- Emits a pattern bitmask and stream position for every match.
- Sits between the byte-stream front end and the match-report logic.

Parameters:
CW, 8, character width in bits (alphabet size 2^CW)
SW, 5, state index width (2^SW automaton states; state 0 = root)
PN, 8, number of patterns (one MATCH_ID bit each)
OFFW, 16, stream position counter width
DW, max(PN, SW+1), configuration data width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-low reset
IN_VALID  in  1  character valid
IN_READY  out  1  engine can accept a character
IN_SOF  in  1  first character of a new stream (sampled with IN_VALID)
IN_CHAR  in  CW  input character
CFG_WE  in  1  table write strobe
CFG_READY  out  1  table write accepted this cycle
CFG_SEL  in  2  0=goto, 1=fail, 2=output, 3=reserved (write ignored)
CFG_ADDR  in  SW+CW  goto: {state,char}; fail/output: state in low SW bits
CFG_DATA  in  DW  goto: {valid,next_state}; fail: next_state; output: PN-bit mask
MATCH_VALID  out  1  one-cycle match pulse
MATCH_ID  out  PN  pattern bitmask of the entered state
MATCH_POS  out  OFFW  0-based position of the last matched character
ERR  out  1  sticky: fail-walk overrun detected

Behaviour:
- Reset (RST=0, asynchronous): FSM=IDLE, cur_state=0, pos=0, step counter=0. MATCH_VALID, MATCH_ID, MATCH_POS and ERR are all 0. Table contents are not reset; every entry must be written before streaming.
- Tables are register arrays with combinational read: goto 2^(SW+CW) x (SW+1), fail 2^SW x SW, output 2^SW x PN. Output masks are already merged along the fail chain by the compiler.
- FSM state IDLE:
  - IN_READY = ~CFG_WE; CFG_READY = 1.
  - A configuration write has priority: CFG_WE=1 writes the selected table at that edge and no character is accepted.
  - Otherwise IN_VALID=1 accepts the character: ch_r<=IN_CHAR.
  - If IN_SOF=1: cur_state<=0 and pos_r<=0. Otherwise pos_r<=pos (pos holds the next position).
  - pos<=pos_r_next+1, wrapping at 2^OFFW. Go to PROBE.
- FSM state PROBE: IN_READY=0, CFG_READY=0. Each cycle looks up goto[cur][ch_r]:
  - Entry valid: cur<=next. MATCH_VALID<=|out[next], MATCH_ID<=out[next], MATCH_POS<=pos_r. Go to IDLE.
  - Entry invalid, cur==0: cur stays 0, no match. Go to IDLE.
  - Entry invalid, cur!=0: cur<=fail[cur], step counter +1, stay in PROBE.
  - Step counter reaches 2^SW-1: ERR<=1, cur<=0, go to IDLE, no match.
- Latency: character accepted at edge k, f = fail steps. New state commits and MATCH_* registers at edge k+1+f. Next accept is possible at edge k+2+f.
- MATCH_VALID is high for exactly one cycle. MATCH_ID and MATCH_POS hold their value until the next commit.
- SOF accepted while cur!=0: the root restart takes precedence, so the probe starts from state 0.
- Position counter wraps from 2^OFFW-1 to 0 silently.
- CFG_WE while in PROBE: CFG_READY=0 and the write is not performed; the writer holds CFG_WE until CFG_READY=1.
- CFG_SEL=3: CFG_READY=1, no table changes.
- ERR is cleared only by reset.
- Reset mid-PROBE: the walk is aborted, no match pulse, state returns to root.

Test Plan:
- Program dictionary {he=bit0, she=bit1, his=bit2, hers=bit3} as states 0..9 (5="she", out=0011; 9="hers", out=1000). Stream "ushers" with SOF on 'u' → MATCH_VALID at 'e' with ID=0011, POS=3; at final 's' with ID=1000, POS=5; no other pulses.
- Same tables, 'r' after "she" → exactly one fail step (5→2, goto(2,'r')=8). Accept edge to commit is 2 cycles and IN_READY is low for 2 cycles.
- Stream "hixhis" with SOF on 'h' → single match, ID=0100, POS=5. 'x' from state 6 walks to root with no match.
- Hold CFG_WE=1 with IN_VALID=1 in IDLE → IN_READY=0 and the table is written. A write attempted during PROBE is held off (CFG_READY=0) and lands after return to IDLE.
- Program fail[1]=2 and fail[2]=1 (cycle), goto misses on both, feed a char in state 1 → ERR=1 after 31 steps, cur=0, no match. Subsequent "he" still matches.
- Assert RST low during a PROBE → all outputs 0 immediately. Restart "he" with SOF → match ID=0001, POS=1. Also run 2^OFFW+2 characters to check POS wraps to 0.

Source files
------------

// File: rtl/ac_stream_matcher.sv
// Runtime-programmable Aho-Corasick matcher. It takes one character per handshake, walks
// goto/fail tables written through a configuration port, and reports a mask/position per match.
module ac_stream_matcher #(
    parameter int CW   = 8,
    parameter int SW   = 5,
    parameter int PN   = 8,
    parameter int OFFW = 16,
    parameter int DW   = (PN > SW + 1) ? PN : SW + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             IN_SOF,
    input  logic [CW-1:0]    IN_CHAR,
    input  logic             CFG_WE,
    output logic             CFG_READY,
    input  logic [1:0]       CFG_SEL,
    input  logic [SW+CW-1:0] CFG_ADDR,
    input  logic [DW-1:0]    CFG_DATA,
    output logic             MATCH_VALID,
    output logic [PN-1:0]    MATCH_ID,
    output logic [OFFW-1:0]  MATCH_POS,
    output logic             ERR
);
    typedef enum logic {S_IDLE, S_PROBE} fsm_t;

    localparam logic [1:0] SEL_GOTO = 2'd0;
    localparam logic [1:0] SEL_FAIL = 2'd1;
    localparam logic [1:0] SEL_OUT  = 2'd2;

    logic [SW:0]   goto_mem [0:(1 << (SW + CW)) - 1];
    logic [SW-1:0] fail_mem [0:(1 << SW) - 1];
    logic [PN-1:0] out_mem  [0:(1 << SW) - 1];

    fsm_t          state_q, state_d;
    logic [SW-1:0] cur_q, cur_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [OFFW-1:0] pos_q, pos_d;
    logic [OFFW-1:0] pos_r_q, pos_r_d;
    logic [SW-1:0] step_q, step_d;
    logic          mv_d, err_d;
    logic [PN-1:0] id_d;
    logic [OFFW-1:0] mpos_d;
    logic [SW:0]   goto_ent;
    logic          cfg_wr;

    assign goto_ent = goto_mem[{cur_q, ch_q}];
    assign cfg_wr   = CFG_WE && (state_q == S_IDLE);

    // NOTE: the tables are plain storage with no reset; software loads every entry before streaming.
    always_ff @(posedge CLK) begin
        if (cfg_wr) begin
            case (CFG_SEL)
                SEL_GOTO: goto_mem[CFG_ADDR]          <= CFG_DATA[SW:0];
                SEL_FAIL: fail_mem[CFG_ADDR[SW-1:0]]  <= CFG_DATA[SW-1:0];
                SEL_OUT:  out_mem[CFG_ADDR[SW-1:0]]   <= CFG_DATA[PN-1:0];
                default:  ;
            endcase
        end
    end

    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        ch_d      = ch_q;
        pos_d     = pos_q;
        pos_r_d   = pos_r_q;
        step_d    = step_q;
        mv_d      = 1'b0;
        id_d      = MATCH_ID;
        mpos_d    = MATCH_POS;
        err_d     = ERR;
        IN_READY  = 1'b0;
        CFG_READY = 1'b0;
        case (state_q)
            S_IDLE: begin
                IN_READY  = ~CFG_WE;
                CFG_READY = 1'b1;
                if (!CFG_WE && IN_VALID) begin
                    ch_d   = IN_CHAR;
                    step_d = '0;
                    if (IN_SOF) begin
                        cur_d   = '0;
                        pos_r_d = '0;
                    end else begin
                        pos_r_d = pos_q;
                    end
                    pos_d   = pos_r_d + 1'b1;
                    state_d = S_PROBE;
                end
            end
            S_PROBE: begin
                // A fail chain this long can only come from a cyclic table; abandon it at the root.
                if (step_q == '1) begin
                    err_d   = 1'b1;
                    cur_d   = '0;
                    state_d = S_IDLE;
                end else if (goto_ent[SW]) begin
                    cur_d   = goto_ent[SW-1:0];
                    id_d    = out_mem[goto_ent[SW-1:0]];
                    mv_d    = |id_d;
                    mpos_d  = pos_r_q;
                    state_d = S_IDLE;
                end else if (cur_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cur_d  = fail_mem[cur_q];
                    step_d = step_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            ch_q        <= '0;
            pos_q       <= '0;
            pos_r_q     <= '0;
            step_q      <= '0;
            MATCH_VALID <= 1'b0;
            MATCH_ID    <= '0;
            MATCH_POS   <= '0;
            ERR         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            ch_q        <= ch_d;
            pos_q       <= pos_d;
            pos_r_q     <= pos_r_d;
            step_q      <= step_d;
            MATCH_VALID <= mv_d;
            MATCH_ID    <= id_d;
            MATCH_POS   <= mpos_d;
            ERR         <= err_d;
        end
    end
endmodule

// File: tb/tb_ac_stream_matcher.sv
// Self-checking bench for ac_stream_matcher: an algorithmic Aho-Corasick model checked every
// cycle, plus literal expectations for the classic he/she/his/hers dictionary.
module tb_ac_stream_matcher;
    localparam int CW   = 8;
    localparam int SW   = 5;
    localparam int PN   = 8;
    localparam int OFFW = 10;   // narrow position counter keeps the wrap run short
    localparam int DW   = 8;
    localparam int NS   = 1 << SW;
    localparam int WRAP = 1 << OFFW;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic IN_VALID = 1'b0, IN_SOF = 1'b0, CFG_WE = 1'b0;
    logic [CW-1:0] IN_CHAR = '0;
    logic [1:0] CFG_SEL = '0;
    logic [SW+CW-1:0] CFG_ADDR = '0;
    logic [DW-1:0] CFG_DATA = '0;
    logic IN_READY, CFG_READY, MATCH_VALID, ERR;
    logic [PN-1:0] MATCH_ID;
    logic [OFFW-1:0] MATCH_POS;

    always #5 CLK = ~CLK;

    ac_stream_matcher #(.CW(CW), .SW(SW), .PN(PN), .OFFW(OFFW), .DW(DW)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_SOF(IN_SOF),
        .IN_CHAR(IN_CHAR), .CFG_WE(CFG_WE), .CFG_READY(CFG_READY), .CFG_SEL(CFG_SEL),
        .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA), .MATCH_VALID(MATCH_VALID),
        .MATCH_ID(MATCH_ID), .MATCH_POS(MATCH_POS), .ERR(ERR)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [SW:0]   m_goto [0:NS-1][0:255];
    logic [SW-1:0] m_fail [0:NS-1];
    logic [PN-1:0] m_out  [0:NS-1];
    logic [SW-1:0] m_cur = '0;
    logic [OFFW-1:0] m_pos = '0, m_mpos = '0, p_pos = '0;
    logic [PN-1:0] m_id = '0, p_id = '0;
    logic m_mv = 1'b0, m_err = 1'b0, p_hit = 1'b0, p_err = 1'b0;
    int m_busy = 0;

    // Resolve one character completely; the walk length sets how long the engine stays busy.
    task automatic model_accept(input logic [CW-1:0] c, input logic sof);
        int steps;
        logic [SW-1:0] s;
        s = sof ? '0 : m_cur;
        p_pos = sof ? '0 : m_pos;
        m_pos = p_pos + 1'b1;
        steps = 0;
        p_hit = 1'b0;
        p_err = 1'b0;
        forever begin
            if (steps == NS - 1) begin p_err = 1'b1; s = '0; break; end
            if (m_goto[s][c][SW]) begin s = m_goto[s][c][SW-1:0]; p_hit = 1'b1; break; end
            if (s == '0) break;
            s = m_fail[s];
            steps++;
        end
        p_id   = m_out[s];
        m_cur  = s;
        m_busy = steps + 1;
    endtask

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_cur = '0; m_pos = '0; m_busy = 0;
            m_mv = 1'b0; m_id = '0; m_mpos = '0; m_err = 1'b0;
        end else begin
            m_mv = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    if (p_err) m_err = 1'b1;
                    if (p_hit) begin m_mv = (p_id != '0); m_id = p_id; m_mpos = p_pos; end
                end
            end else if (CFG_WE) begin
                case (CFG_SEL)
                    2'd0: m_goto[CFG_ADDR[SW+CW-1:CW]][CFG_ADDR[CW-1:0]] = CFG_DATA[SW:0];
                    2'd1: m_fail[CFG_ADDR[SW-1:0]] = CFG_DATA[SW-1:0];
                    2'd2: m_out[CFG_ADDR[SW-1:0]]  = CFG_DATA[PN-1:0];
                    default: ;
                endcase
            end else if (IN_VALID) begin
                model_accept(IN_CHAR, IN_SOF);
            end
        end
    end

    // Compare DUT against the model every cycle, after inputs and outputs have settled.
    initial begin
        forever begin
            @(negedge CLK);
            #3;
            if (cmp_en) begin
                check("match_valid", MATCH_VALID, m_mv);
                check("match_id", MATCH_ID, m_id);
                check("match_pos", MATCH_POS, m_mpos);
                check("err", ERR, m_err);
                check("in_ready", IN_READY, (m_busy == 0) && !CFG_WE);
                check("cfg_ready", CFG_READY, m_busy == 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    int hit_id[$], hit_pos[$], lats[$];

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input int addr, input int data, output int waited);
        CFG_SEL = sel; CFG_ADDR = addr[SW+CW-1:0]; CFG_DATA = data[DW-1:0]; CFG_WE = 1'b1;
        #1;
        waited = 0;
        while (!CFG_READY && waited < 100) begin tick(); waited++; end
        if (!CFG_READY) check("cfg_ready_timeout", CFG_READY, 1);
        tick();
        CFG_WE = 1'b0;
    endtask

    task automatic send_char(input logic [CW-1:0] c, input logic sof);
        int n;
        n = 0;
        IN_CHAR = c; IN_SOF = sof; IN_VALID = 1'b1;
        #1;
        while (!IN_READY && n < 100) begin tick(); #1; n++; end
        if (!IN_READY) check("in_ready_timeout", IN_READY, 1);
        tick();
        IN_VALID = 1'b0; IN_SOF = 1'b0;
    endtask

    task automatic wait_idle(output int lat);
        lat = 0;
        while (!CFG_READY && lat < 100) begin tick(); lat++; end
        if (!CFG_READY) check("idle_timeout", CFG_READY, 1);
    endtask

    task automatic capture();
        if (MATCH_VALID) begin hit_id.push_back(int'(MATCH_ID)); hit_pos.push_back(int'(MATCH_POS)); end
    endtask

    task automatic clear_log();
        hit_id.delete(); hit_pos.delete(); lats.delete();
    endtask

    task automatic feed(input string s, input bit sof);
        int lat;
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i], sof && (i == 0));
            wait_idle(lat);
            lats.push_back(lat);
            capture();
        end
    endtask

    task automatic check_hit(input string name, input int idx, input int id, input int pos);
        check({name, "_id"}, (hit_id.size() > idx) ? hit_id[idx] : -1, id);
        check({name, "_pos"}, (hit_pos.size() > idx) ? hit_pos[idx] : -1, pos);
    endtask

    // Trie for {he, she, his, hers}; output masks already merged along the fail chain.
    int e_from[9] = '{0, 1, 2, 8, 1, 6, 0, 3, 4};
    byte e_ch[9]  = '{"h", "e", "r", "s", "i", "s", "s", "h", "e"};
    int e_to[9]   = '{1, 2, 8, 9, 6, 7, 3, 4, 5};
    int f_init[10] = '{0, 0, 0, 0, 1, 2, 0, 3, 0, 3};
    int o_init[10] = '{0, 0, 1, 0, 0, 3, 0, 4, 0, 8};

    task automatic program_dict();
        int w, d;
        for (int s = 0; s < 10; s++) begin
            for (int c = 0; c < 256; c++) begin
                d = 0;
                for (int e = 0; e < 9; e++)
                    if (e_from[e] == s && int'(e_ch[e]) == c) d = 32 | e_to[e];
                cfg_write(2'd0, (s << 8) | c, d, w);
            end
        end
        for (int s = 0; s < NS; s++) begin
            cfg_write(2'd1, s, (s < 10) ? f_init[s] : 0, w);
            cfg_write(2'd2, s, (s < 10) ? o_init[s] : 0, w);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w, lat;
        #2 RST = 1'b0;
        #1 cmp_en = 1'b1;
        check("rst_match_valid", MATCH_VALID, 0);
        check("rst_match_id", MATCH_ID, 0);
        check("rst_match_pos", MATCH_POS, 0);
        check("rst_err", ERR, 0);
        check("rst_in_ready", IN_READY, 1);
        check("rst_cfg_ready", CFG_READY, 1);
        tick(); tick();
        RST = 1'b1;
        tick();

        program_dict();
        cfg_write(2'd3, 5, 8'hFF, w);
        check("sel3_accepted_at_once", w, 0);

        clear_log();
        feed("ushers", 1'b1);
        check("ushers_hits", hit_id.size(), 2);
        check_hit("ushers_she", 0, 3, 3);
        check_hit("ushers_hers", 1, 8, 5);
        check("ushers_lat_e", lats[3], 1);
        check("ushers_lat_r_one_fail", lats[4], 2);

        clear_log();
        feed("hixhis", 1'b1);
        check("hixhis_hits", hit_id.size(), 1);
        check_hit("hixhis_his", 0, 4, 5);
        check("hixhis_lat_x", lats[2], 2);

        // Config write and a character offered together: the write wins.
        clear_log();
        CFG_SEL = 2'd2; CFG_ADDR = 2; CFG_DATA = 8'h10; CFG_WE = 1'b1;
        IN_CHAR = "h"; IN_SOF = 1'b1; IN_VALID = 1'b1;
        #1;
        check("prio_in_ready", IN_READY, 0);
        check("prio_cfg_ready", CFG_READY, 1);
        tick();
        CFG_WE = 1'b0;
        #1;
        check("prio_in_ready_after", IN_READY, 1);
        tick();
        IN_VALID = 1'b0; IN_SOF = 1'b0;
        wait_idle(lat);
        feed("e", 1'b0);
        check_hit("prio_new_mask", 0, 8'h10, 1);

        // Write attempted mid-walk is held off until the engine is idle again.
        clear_log();
        feed("h", 1'b1);
        send_char("x", 1'b0);
        CFG_SEL = 2'd2; CFG_ADDR = 2; CFG_DATA = 8'h01; CFG_WE = 1'b1;
        #1;
        check("hold_cfg_ready_probe", CFG_READY, 0);
        cfg_write(2'd2, 2, 8'h01, w);
        check("hold_wait_cycles", w, 2);
        feed("he", 1'b1);
        check_hit("hold_restored", 0, 1, 1);

        // Cyclic fail chain trips the overrun detector.
        clear_log();
        cfg_write(2'd1, 1, 2, w);
        cfg_write(2'd1, 2, 1, w);
        feed("hz", 1'b1);
        check("cycle_err", ERR, 1);
        check("cycle_lat", lats[1], 32);
        check("cycle_no_hit", hit_id.size(), 0);
        feed("he", 1'b1);
        check_hit("cycle_then_he", 0, 1, 1);
        check("cycle_err_sticky", ERR, 1);

        // Reset in the middle of a long walk.
        feed("h", 1'b1);
        send_char("z", 1'b0);
        tick(); tick();
        RST = 1'b0;
        #1;
        check("rst_mid_valid", MATCH_VALID, 0);
        check("rst_mid_id", MATCH_ID, 0);
        check("rst_mid_pos", MATCH_POS, 0);
        check("rst_mid_err", ERR, 0);
        tick();
        RST = 1'b1;
        tick();
        cfg_write(2'd1, 1, 0, w);
        cfg_write(2'd1, 2, 0, w);
        clear_log();
        feed("he", 1'b1);
        check("after_rst_hits", hit_id.size(), 1);
        check_hit("after_rst_he", 0, 1, 1);

        // Position counter wrap: "he" straddles the wrap so the match lands on position 0.
        clear_log();
        for (int i = 0; i < WRAP + 2; i++) begin
            logic [CW-1:0] c;
            c = (i == WRAP - 1) ? 8'h68 : (i == WRAP) ? 8'h65 : 8'h78;
            send_char(c, i == 0);
            wait_idle(lat);
            capture();
        end
        check("wrap_hits", hit_id.size(), 1);
        check_hit("wrap_he", 0, 1, 0);

        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
